wash_program_sequencer: RTL
===========================

// Module: wash_program_sequencer
// PURPOSE
//  Washing-machine program controller. Sequences the wash datapath through fill/wash/drain/rinse/spin
//  phases per selected program: drives valve, drain pump, motor on/fast and door lock from phase timers.
//  Sits above the motor/speed block; its motor_on/motor_fast feed that block's on_off/speed.
// PARAMETERS
//  CNT_W    16  width of phase timer (ticks)
//  TICK_DIV 10  clk cycles per timer tick (>=1)
//  T_FILL   20  fill timeout, ticks (>=1)
//  T_WASH  100  wash duration, ticks (>=1)
//  T_RINSE  60  rinse duration, ticks (>=1)
//  T_DRAIN  20  drain duration, ticks (>=1)
//  T_SPIN   80  spin duration, ticks (>=1)
// PORTS
//  clk         in  1  system clock, rising edge
//  rst         in  1  synchronous reset, active-low
//  start       in  1  start request, sampled each cycle
//  pause       in  1  level; freezes active phase
//  door_closed in  1  door sensor, 1 = closed
//  water_full  in  1  level sensor, 1 = drum full
//  prog_sel    in  2  00 normal, 01 quick, 10 spin-only, 11 rinse+spin; sampled on accepted start only
//  valve_on    out 1  inlet valve
//  drain_on    out 1  drain pump
//  motor_on    out 1  drum motor enable
//  motor_fast  out 1  high speed (spin)
//  door_lock   out 1  door locked
//  phase       out 3  0 IDLE,1 FILL,2 WASH,3 RINSE,4 DRAIN,5 SPIN,6 DONE,7 FAULT
//  done        out 1  1-cycle pulse, high exactly while phase==DONE
//  error       out 1  high while phase==FAULT
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): phase=IDLE, all outputs 0, flags/timer/prescaler cleared. Mid-program too.
//  - All outputs registered; combinational decode of phase register only.
//  - IDLE: start&&door_closed -> load wash_pend/rinse_pend from prog_sel; next = FILL, or DRAIN for 10.
//    Flags: 00 W=1 R=1; 01 W=1 R=0; 10 W=0 R=0; 11 W=0 R=1. start with door open ignored.
//  - Sequences: 00 FILL,WASH,DRAIN,FILL,RINSE,DRAIN,SPIN; 01 FILL,WASH,DRAIN,SPIN;
//    10 DRAIN,SPIN; 11 FILL,RINSE,DRAIN,SPIN; then DONE (1 cycle) -> IDLE.
//  - FILL: valve_on. water_full high -> WASH if wash_pend (clear it) else RINSE (clear rinse_pend).
//    T_FILL ticks elapse without water_full -> FAULT. Same cycle both: water_full wins.
//  - WASH/RINSE: motor_on, timed. DRAIN: drain_on, timed; then FILL if rinse_pend else SPIN.
//  - SPIN: motor_on+motor_fast, timed. Timed phase with param T lasts exactly T*TICK_DIV un-paused cycles.
//  - Timer: prescaler+down counter reloaded on every phase entry; prescaler restarts at 0 on entry.
//  - door_lock=1 in FILL..SPIN and FAULT; 0 in IDLE, DONE.
//  - pause (FILL..SPIN): valve/drain/motor/motor_fast forced 0, timer+prescaler frozen, phase held,
//    water_full ignored while paused. Release resumes with remaining count.
//  - door_closed==0 in FILL..SPIN -> FAULT next cycle; has priority over pause and phase expiry.
//  - FAULT: actuators 0, door_lock=1, error=1; left only by reset. start ignored outside IDLE.
// CONFIGURATION
//  WASH_TIME_LEFT_EN defined: extra output time_left[CNT_W-1:0] = remaining ticks of current phase
//    (frozen under pause; 0 in IDLE/DONE/FAULT; reset 0).
//  Not defined: port absent, no extra logic; all other behaviour identical.
// STRUCTURE
//  wash_pkg: phase codes (IDLE..FAULT, 3-bit), program codes (PROG_NORMAL/QUICK/SPIN/RINSE).
//  Sub-module wash_phase_timer: prescaler + CNT_W down counter; in load, load_val, freeze; out expired.
//  Top: phase FSM, pending flags, output decode.
// TESTING (bench params: TICK_DIV=2,T_FILL=4,T_WASH=3,T_RINSE=2,T_DRAIN=2,T_SPIN=3)
//  1 rst=0 two cycles with start=1 -> phase=0, all outputs 0; release, start with door_closed=0 -> stays IDLE.
//  2 prog 00, water_full after 2 cycles each FILL -> phases 1,2,4,1,3,4,5,6,0; WASH 6, DRAIN 4, SPIN 6 cycles; done 1 cycle.
//  3 prog 10 -> 4 (4 cycles), 5 (6 cycles, motor_fast=1), 6, 0; valve_on never 1.
//  4 prog 01, water_full never -> FILL 8 cycles then phase=7, error=1, door_lock=1; start ignored; rst clears.
//  5 WASH, pause 5 cycles mid-phase -> motor_on=0, phase held; WASH total 6 un-paused cycles;
//    door_closed=0 during pause -> FAULT next cycle.
//  6 WASH_TIME_LEFT_EN: time_left=3 on WASH entry, 2 after 2 cycles, frozen under pause, 0 in DONE.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared phase and program codes for the washing-machine program sequencer.
package wash_pkg;

   typedef enum logic [2:0] {
      PH_IDLE  = 3'd0,
      PH_FILL  = 3'd1,
      PH_WASH  = 3'd2,
      PH_RINSE = 3'd3,
      PH_DRAIN = 3'd4,
      PH_SPIN  = 3'd5,
      PH_DONE  = 3'd6,
      PH_FAULT = 3'd7
   } phase_e;

   typedef enum logic [1:0] {
      PROG_NORMAL = 2'b00,
      PROG_QUICK  = 2'b01,
      PROG_SPIN   = 2'b10,
      PROG_RINSE  = 2'b11
   } prog_e;

   typedef struct packed {
      logic valve;
      logic drain;
      logic motor;
      logic fast;
   } act_t;

   function automatic logic is_active(input phase_e p);
      return (p >= PH_FILL) && (p <= PH_SPIN);
   endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Phase timer: prescaler divides clk into ticks, down counter holds remaining ticks.
// With WASH_TIME_LEFT_EN defined the remaining count is exported as count.
module wash_phase_timer #(
   parameter int CNT_W    = 16,
   parameter int TICK_DIV = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             freeze,
`ifdef WASH_TIME_LEFT_EN
   output logic [CNT_W-1:0] count,
`endif
   output logic             expired
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] presc_q, presc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;

   assign tick = (presc_q == PRE_MAX);
   // Last cycle of the last tick: the owning phase leaves on this edge.
   assign expired = tick && (cnt_q == CNT_W'(1));

`ifdef WASH_TIME_LEFT_EN
   assign count = cnt_q;
`endif

   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      if (load) begin
         presc_d = '0;
         cnt_d   = load_val;
      end else if (!freeze && (cnt_q != '0)) begin
         if (tick) begin
            presc_d = '0;
            cnt_d   = cnt_q - CNT_W'(1);
         end else begin
            presc_d = presc_q + PRE_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/wash_program_sequencer.sv
// Washing-machine program controller: phase FSM, pending wash/rinse flags, registered actuators.
// Optional WASH_TIME_LEFT_EN adds the time_left output (remaining ticks of the current phase).
module wash_program_sequencer
   import wash_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int TICK_DIV = 10,
   parameter int T_FILL   = 20,
   parameter int T_WASH   = 100,
   parameter int T_RINSE  = 60,
   parameter int T_DRAIN  = 20,
   parameter int T_SPIN   = 80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       door_closed,
   input  logic       water_full,
   input  logic [1:0] prog_sel,
   output logic       valve_on,
   output logic       drain_on,
   output logic       motor_on,
   output logic       motor_fast,
   output logic       door_lock,
   output logic [2:0] phase,
   output logic       done,
   output logic       error
`ifdef WASH_TIME_LEFT_EN
   ,
   output logic [CNT_W-1:0] time_left
`endif
);

   phase_e           phase_q, phase_d;
   logic             wash_pend_q, wash_pend_d;
   logic             rinse_pend_q, rinse_pend_d;
   act_t             act_q, act_d;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             expired;
   logic             active;

   assign active = is_active(phase_q);
   assign load   = (phase_d != phase_q);

   always_comb begin
      case (phase_d)
         PH_FILL:  load_val = CNT_W'(T_FILL);
         PH_WASH:  load_val = CNT_W'(T_WASH);
         PH_RINSE: load_val = CNT_W'(T_RINSE);
         PH_DRAIN: load_val = CNT_W'(T_DRAIN);
         PH_SPIN:  load_val = CNT_W'(T_SPIN);
         default:  load_val = '0;
      endcase
   end

   wash_phase_timer #(
      .CNT_W    (CNT_W),
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .freeze   (pause),
`ifdef WASH_TIME_LEFT_EN
      .count    (time_left),
`endif
      .expired  (expired)
   );

   always_comb begin
      phase_d      = phase_q;
      wash_pend_d  = wash_pend_q;
      rinse_pend_d = rinse_pend_q;
      // An open door during a running program beats pause and timer expiry.
      if (active && !door_closed) begin
         phase_d = PH_FAULT;
      end else if (active && pause) begin
         phase_d = phase_q;
      end else begin
         case (phase_q)
            PH_IDLE: begin
               if (start && door_closed) begin
                  case (prog_e'(prog_sel))
                     PROG_NORMAL: begin wash_pend_d = 1'b1; rinse_pend_d = 1'b1; end
                     PROG_QUICK:  begin wash_pend_d = 1'b1; rinse_pend_d = 1'b0; end
                     PROG_SPIN:   begin wash_pend_d = 1'b0; rinse_pend_d = 1'b0; end
                     default:     begin wash_pend_d = 1'b0; rinse_pend_d = 1'b1; end
                  endcase
                  phase_d = (prog_e'(prog_sel) == PROG_SPIN) ? PH_DRAIN : PH_FILL;
               end
            end
            PH_FILL: begin
               if (water_full) begin
                  if (wash_pend_q) begin
                     phase_d     = PH_WASH;
                     wash_pend_d = 1'b0;
                  end else begin
                     phase_d      = PH_RINSE;
                     rinse_pend_d = 1'b0;
                  end
               end else if (expired) begin
                  phase_d = PH_FAULT;
               end
            end
            PH_WASH, PH_RINSE: if (expired) phase_d = PH_DRAIN;
            PH_DRAIN:          if (expired) phase_d = rinse_pend_q ? PH_FILL : PH_SPIN;
            PH_SPIN:           if (expired) phase_d = PH_DONE;
            PH_DONE:           phase_d = PH_IDLE;
            default:           phase_d = PH_FAULT;
         endcase
      end
   end

   always_comb begin
      act_d = '0;
      if (!pause) begin
         act_d.valve = (phase_d == PH_FILL);
         act_d.drain = (phase_d == PH_DRAIN);
         act_d.motor = (phase_d == PH_WASH) || (phase_d == PH_RINSE) || (phase_d == PH_SPIN);
         act_d.fast  = (phase_d == PH_SPIN);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_q      <= PH_IDLE;
         wash_pend_q  <= 1'b0;
         rinse_pend_q <= 1'b0;
         act_q        <= '0;
      end else begin
         phase_q      <= phase_d;
         wash_pend_q  <= wash_pend_d;
         rinse_pend_q <= rinse_pend_d;
         act_q        <= act_d;
      end
   end

   assign valve_on   = act_q.valve;
   assign drain_on   = act_q.drain;
   assign motor_on   = act_q.motor;
   assign motor_fast = act_q.fast;
   assign door_lock  = active || (phase_q == PH_FAULT);
   assign phase      = phase_q;
   assign done       = (phase_q == PH_DONE);
   assign error      = (phase_q == PH_FAULT);

endmodule
